// File: rtl/div_pkg.sv
// Shared types and constants for the divisible-by-12 sharing arbiter and its checker.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } div_state_e;

    localparam int DIV_OP_W = 4;

    localparam logic [DIV_OP_W-1:0] DIV_HIT_A = 4'd0;
    localparam logic [DIV_OP_W-1:0] DIV_HIT_B = 4'd12;

endpackage

// File: rtl/div12_check.sv
// Combinational 4-bit divisible-by-3-and-4 checker built from NOR terms.
// Zero latency; no flow control. The output is 1 only for 0 and 12.
module div12_check
    import div_pkg::*;
(
    input  logic [DIV_OP_W-1:0] op_i,
    output logic                div_o
);

    logic both_lo;
    logic n3;
    logic n2;
    logic both_hi;
    logic hi_ne;

    // The top two bits must match; the low two bits must be zero.
    assign both_lo = ~(op_i[3] | op_i[2]);
    assign n3      = ~(op_i[3] | op_i[3]);
    assign n2      = ~(op_i[2] | op_i[2]);
    assign both_hi = ~(n3 | n2);
    assign hi_ne   = ~(both_lo | both_hi);
    assign div_o   = ~(hi_ne | op_i[1] | op_i[0]);

endmodule

// File: rtl/div12_share_arbiter.sv
// Round-robin share of one div12 checker; grant-to-valid 2 cycles, one txn per 3 cycles.
// A stalled response (rsp_ready_i low) holds RESP and blocks all further grants.
module div12_share_arbiter
    import div_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int STAT_W  = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NUM_REQ-1:0]           req_i,
    input  logic [DIV_OP_W*NUM_REQ-1:0]  data_i,
    output logic [NUM_REQ-1:0]           gnt_o,
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,
    output logic [ID_W-1:0]              rsp_id_o,
    output logic [DIV_OP_W-1:0]          rsp_data_o,
    output logic                         rsp_div_o,
    output logic                         busy_o,
    output logic [STAT_W-1:0]            req_cnt_o,
    output logic [STAT_W-1:0]            hit_cnt_o
);

    localparam int PW = ID_W + 1;

    localparam logic [1:0] S_IDLE = 2'(IDLE);
    localparam logic [1:0] S_EVAL = 2'(EVAL);
    localparam logic [1:0] S_RESP = 2'(RESP);

    // Returns {found, index}: first set request at or above ptr, wrapping.
    function automatic logic [PW-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                              input logic [ID_W-1:0]    ptr);
        logic [PW-1:0] res;
        logic [PW-1:0] idx;
        res = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = {1'b0, ptr} + PW'(i);
            if (idx >= PW'(NUM_REQ)) begin
                idx = idx - PW'(NUM_REQ);
            end
            if (req[idx[ID_W-1:0]]) begin
                res = {1'b1, idx[ID_W-1:0]};
            end
        end
        return res;
    endfunction

    logic [1:0]           state_q,   state_d;
    logic [ID_W-1:0]      ptr_q,     ptr_d;
    logic [DIV_OP_W-1:0]  op_q,      op_d;
    logic [ID_W-1:0]      id_q,      id_d;
    logic                 div_q,     div_d;
    logic [STAT_W-1:0]    req_cnt_q, req_cnt_d;
    logic [STAT_W-1:0]    hit_cnt_q, hit_cnt_d;

    logic [PW-1:0]        pick;
    logic                 pick_vld;
    logic [ID_W-1:0]      pick_idx;
    logic [NUM_REQ-1:0]   gnt_c;
    logic                 chk_div;

    assign pick     = rr_pick(req_i, ptr_q);
    assign pick_vld = pick[ID_W];
    assign pick_idx = pick[ID_W-1:0];

    div12_check u_check (
        .op_i  (op_q),
        .div_o (chk_div)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        op_d      = op_q;
        id_d      = id_q;
        div_d     = div_q;
        req_cnt_d = req_cnt_q;
        hit_cnt_d = hit_cnt_q;
        gnt_c     = '0;
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    gnt_c[pick_idx] = 1'b1;
                    op_d            = data_i[pick_idx*DIV_OP_W +: DIV_OP_W];
                    id_d            = pick_idx;
                    ptr_d           = (pick_idx == ID_W'(NUM_REQ - 1)) ? '0
                                                                       : pick_idx + ID_W'(1);
                    state_d         = S_EVAL;
                end
            end
            S_EVAL: begin
                div_d   = chk_div;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    if (req_cnt_q != {STAT_W{1'b1}}) begin
                        req_cnt_d = req_cnt_q + STAT_W'(1);
                    end
                    if (div_q && (hit_cnt_q != {STAT_W{1'b1}})) begin
                        hit_cnt_d = hit_cnt_q + STAT_W'(1);
                    end
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            op_q      <= '0;
            id_q      <= '0;
            div_q     <= 1'b0;
            req_cnt_q <= '0;
            hit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            op_q      <= op_d;
            id_q      <= id_d;
            div_q     <= div_d;
            req_cnt_q <= req_cnt_d;
            hit_cnt_q <= hit_cnt_d;
        end
    end

    // Grant is suppressed under reset so no capture is ever advertised then.
    assign gnt_o       = rst_i ? '0 : gnt_c;
    assign rsp_valid_o = (state_q == S_RESP);
    assign busy_o      = (state_q != S_IDLE);
    assign rsp_id_o    = id_q;
    assign rsp_data_o  = op_q;
    assign rsp_div_o   = div_q;
    assign req_cnt_o   = req_cnt_q;
    assign hit_cnt_o   = hit_cnt_q;

endmodule

// File: tb/tb_div12_share_arbiter.sv
// Directed bench: reset, exhaustive operands, round-robin, backpressure, mid-op reset, saturation.
module tb_div12_share_arbiter;
    import div_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [3:0]  req_i;
    logic [15:0] data_i;
    logic [3:0]  gnt_o;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [1:0]  rsp_id_o;
    logic [3:0]  rsp_data_o;
    logic        rsp_div_o;
    logic        busy_o;
    logic [7:0]  req_cnt_o;
    logic [7:0]  hit_cnt_o;

    logic [3:0]  s_req;
    logic [15:0] s_data;
    logic [3:0]  s_gnt;
    logic        s_valid;
    logic        s_ready;
    logic [1:0]  s_id;
    logic [3:0]  s_rdata;
    logic        s_div;
    logic        s_busy;
    logic [1:0]  s_req_cnt;
    logic [1:0]  s_hit_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    div12_share_arbiter #(.NUM_REQ(4), .STAT_W(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .data_i(data_i),
        .gnt_o(gnt_o), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_id_o(rsp_id_o), .rsp_data_o(rsp_data_o), .rsp_div_o(rsp_div_o),
        .busy_o(busy_o), .req_cnt_o(req_cnt_o), .hit_cnt_o(hit_cnt_o)
    );

    div12_share_arbiter #(.NUM_REQ(4), .STAT_W(2)) dut_sat (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(s_req), .data_i(s_data),
        .gnt_o(s_gnt), .rsp_valid_o(s_valid), .rsp_ready_i(s_ready),
        .rsp_id_o(s_id), .rsp_data_o(s_rdata), .rsp_div_o(s_div),
        .busy_o(s_busy), .req_cnt_o(s_req_cnt), .hit_cnt_o(s_hit_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
    endtask

    // One transaction from a lone requester k with ready high.
    task automatic single(input int k, input logic [3:0] v, input logic exp_div);
        req_i           = 4'(1 << k);
        data_i[4*k +: 4] = v;
        rsp_ready_i     = 1'b1;
        #1;
        chk("single_gnt", gnt_o, 32'(1 << k));
        tick();
        req_i = '0;
        chk("single_eval_busy", busy_o, 1);
        chk("single_eval_gnt", gnt_o, 0);
        tick();
        chk("single_valid", rsp_valid_o, 1);
        chk("single_id", rsp_id_o, k);
        chk("single_data", rsp_data_o, v);
        chk("single_div", rsp_div_o, exp_div);
        tick();
        chk("single_done_valid", rsp_valid_o, 0);
    endtask

    logic [3:0] rr_op  [4];
    logic       rr_div [4];

    initial begin
        rr_op  = '{4'd3, 4'd4, 4'd12, 4'd0};
        rr_div = '{1'b0, 1'b0, 1'b1, 1'b1};
        rst_i = 1'b1; req_i = '0; data_i = '0; rsp_ready_i = 1'b1;
        s_req = '0; s_data = '0; s_ready = 1'b1;

        // Reset state
        tick(); tick();
        chk("rst_gnt", gnt_o, 0);
        chk("rst_valid", rsp_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_id", rsp_id_o, 0);
        chk("rst_data", rsp_data_o, 0);
        chk("rst_div", rsp_div_o, 0);
        chk("rst_req_cnt", req_cnt_o, 0);
        chk("rst_hit_cnt", hit_cnt_o, 0);
        rst_i = 1'b0;

        // Single request of a hit value
        single(0, DIV_HIT_B, 1'b1);
        chk("first_req_cnt", req_cnt_o, 1);
        chk("first_hit_cnt", hit_cnt_o, 1);

        // Exhaustive operands from requester 2
        do_reset();
        chk("rst2_req_cnt", req_cnt_o, 0);
        for (int v = 0; v < 16; v++) begin
            single(2, 4'(v), (4'(v) == DIV_HIT_A) || (4'(v) == DIV_HIT_B));
        end
        chk("exh_req_cnt", req_cnt_o, 16);
        chk("exh_hit_cnt", hit_cnt_o, 2);

        // Round-robin with all four requesting
        do_reset();
        req_i  = 4'b1111;
        data_i = {4'd0, 4'd12, 4'd4, 4'd3};
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("rr_gnt", gnt_o, 32'(1 << (i % 4)));
            tick();
            chk("rr_eval_gnt", gnt_o, 0);
            tick();
            chk("rr_id", rsp_id_o, i % 4);
            chk("rr_data", rsp_data_o, rr_op[i % 4]);
            chk("rr_div", rsp_div_o, rr_div[i % 4]);
            tick();
        end
        chk("rr_req_cnt", req_cnt_o, 5);
        chk("rr_hit_cnt", hit_cnt_o, 2);

        // Backpressure: pointer is now 1, so requester 1 wins first, then 2
        req_i       = 4'b0110;
        data_i      = {4'd0, 4'd8, 4'd5, 4'd3};
        rsp_ready_i = 1'b0;
        #1;
        chk("bp_gnt1", gnt_o, 4'b0010);
        tick();
        chk("bp_eval_gnt", gnt_o, 0);
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", rsp_valid_o, 1);
            chk("bp_id", rsp_id_o, 1);
            chk("bp_data", rsp_data_o, 5);
            chk("bp_div", rsp_div_o, 0);
            chk("bp_gnt_hold", gnt_o, 0);
            tick();
        end
        rsp_ready_i = 1'b1;
        #1;
        chk("bp_valid_last", rsp_valid_o, 1);
        tick();
        chk("bp_gnt2", gnt_o, 4'b0100);
        chk("bp_req_cnt", req_cnt_o, 6);
        tick();
        req_i = '0;
        tick();
        chk("bp_id2", rsp_id_o, 2);
        chk("bp_data2", rsp_data_o, 8);
        tick();

        // Reset during EVAL; pointer is 3, so requester 1 wins here
        req_i  = 4'b0010;
        data_i = {4'd0, 4'd8, 4'd12, 4'd9};
        #1;
        chk("mr_gnt", gnt_o, 4'b0010);
        tick();
        chk("mr_eval_busy", busy_o, 1);
        rst_i = 1'b1;
        req_i = 4'b1111;
        tick();
        chk("mr_busy", busy_o, 0);
        chk("mr_valid", rsp_valid_o, 0);
        chk("mr_req_cnt", req_cnt_o, 0);
        chk("mr_hit_cnt", hit_cnt_o, 0);
        chk("mr_gnt_rst", gnt_o, 0);
        rst_i = 1'b0;
        #1;
        chk("mr_gnt_ptr0", gnt_o, 4'b0001);
        tick();
        req_i = '0;
        chk("mr_eval_valid", rsp_valid_o, 0);
        tick();
        chk("mr_valid2", rsp_valid_o, 1);
        chk("mr_id", rsp_id_o, 0);
        chk("mr_data", rsp_data_o, 9);
        chk("mr_div", rsp_div_o, 0);
        tick();
        chk("mr_req_cnt2", req_cnt_o, 1);
        chk("mr_hit_cnt2", hit_cnt_o, 0);

        // Saturation with 2-bit counters, operand 0 from requester 0
        s_req  = 4'b0001;
        s_data = '0;
        repeat (6) tick();
        chk("sat_req_cnt2", s_req_cnt, 2);
        chk("sat_hit_cnt2", s_hit_cnt, 2);
        repeat (9) tick();
        s_req = '0;
        chk("sat_req_cnt", s_req_cnt, 3);
        chk("sat_hit_cnt", s_hit_cnt, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
